// File: rtl/sticky_accum_unit_pkg.sv
// rtl/sticky_accum_unit_pkg.sv - shared FSM states and default parameters for the sticky accumulator
package sticky_accum_unit_pkg;

    localparam int LANES_DEF     = 4;
    localparam int FRAC_W_DEF    = 24;
    localparam int MAX_BEATS_DEF = 4;
    localparam int CNT_W_DEF     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sticky_lane_acc.sv
// rtl/sticky_lane_acc.sv - one lane of OR/AND sticky accumulation; optional guard via STICKY_GUARD_EN
module sticky_lane_acc #(
    parameter int FRAC_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              accum,
    input  logic [FRAC_W-1:0] beat,
    input  logic              inv,
    input  logic              en,
    output logic              st1,
    output logic              compen
`ifdef STICKY_GUARD_EN
    ,
    output logic              guard
`endif
);

    logic or_acc;
    logic and_acc;
    logic inv_lat;
    logic en_lat;
    logic load_or;
    logic load_and;

`ifdef STICKY_GUARD_EN
    // The MSB of the first beat is the guard bit and stays out of the sticky reduction.
    localparam logic [FRAC_W-1:0] GUARD_MASK = FRAC_W'(1) << (FRAC_W - 1);
    logic guard_lat;

    assign load_or  = |(beat & ~GUARD_MASK);
    assign load_and = &(beat | GUARD_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_lat <= 1'b0;
        end else if (load) begin
            guard_lat <= beat[FRAC_W-1];
        end
    end

    assign guard = en_lat & (guard_lat ^ inv_lat);
`else
    assign load_or  = |beat;
    assign load_and = &beat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_acc  <= 1'b0;
            and_acc <= 1'b1;
            inv_lat <= 1'b0;
            en_lat  <= 1'b0;
        end else if (load) begin
            or_acc  <= load_or;
            and_acc <= load_and;
            inv_lat <= inv;
            en_lat  <= en;
        end else if (accum) begin
            or_acc  <= or_acc | (|beat);
            and_acc <= and_acc & (&beat);
        end
    end

    assign st1    = en_lat & (inv_lat ? ~and_acc : or_acc);
    assign compen = en_lat & inv_lat & and_acc;

endmodule

// File: rtl/sticky_accum_unit.sv
// rtl/sticky_accum_unit.sv - multi-lane multi-beat sticky/compensation generator; STICKY_GUARD_EN adds out_guard
module sticky_accum_unit
    import sticky_accum_unit_pkg::*;
#(
    parameter int LANES     = LANES_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [LANES*FRAC_W-1:0] in_frac,
    input  logic [LANES-1:0]        in_inv_mask,
    input  logic [LANES-1:0]        in_lane_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_st1,
    output logic [LANES-1:0]        out_compen,
    output logic [CNT_W-1:0]        out_beats,
    output logic                    out_err
`ifdef STICKY_GUARD_EN
    ,
    output logic [LANES-1:0]        out_guard
`endif
);

    localparam logic [CNT_W-1:0] BEAT_SAT = CNT_W'(MAX_BEATS);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             load;
    logic             accum;
    logic [CNT_W-1:0] beats;
    logic             err;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A first beat restarts the operation in both IDLE and ACCUM; non-first beats in IDLE are dropped.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        accum     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_first) begin
                    load      = 1'b1;
                    state_nxt = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load  = in_first;
                    accum = ~in_first;
                    if (in_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            if (load) begin
                beats <= CNT_W'(1);
                err   <= (state == ACCUM);
            end else if (accum) begin
                if (beats == BEAT_SAT) begin
                    err <= 1'b1;
                end else begin
                    beats <= beats + CNT_W'(1);
                end
            end
        end
    end

    assign out_beats = beats;
    assign out_err   = err;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sticky_lane_acc #(
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .accum  (accum),
            .beat   (in_frac[i*FRAC_W +: FRAC_W]),
            .inv    (in_inv_mask[i]),
            .en     (in_lane_en[i]),
            .st1    (out_st1[i]),
            .compen (out_compen[i])
`ifdef STICKY_GUARD_EN
            ,
            .guard  (out_guard[i])
`endif
        );
    end

endmodule
